// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
//   Write-back, write-allocate data-cache controller placed between the CPU
//   memory stage, a 2-way tag/data SRAM (dcache_sram) and a 256-bit memory.
//   Geometry: 32-byte lines, 16 sets, 23-bit tag, 32-bit words.
//   Hits complete in the same cycle. A miss stalls the CPU, writes back a
//   dirty victim if needed, refills the line and then retires as a hit.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   cpu_addr_i          byte address: [31:9] tag, [8:5] index, [4:2] word
//   cpu_data_i          store data
//   cpu_MemRead_i       load request (level)
//   cpu_MemWrite_i      store request (level)
//   cpu_data_o          load data, valid with a request and no stall
//   cpu_stall_o         CPU must hold its request while high
//   sram_addr_o         set index
//   sram_tag_o          {valid, dirty, tag}
//   sram_data_o         line write data
//   sram_enable_o       SRAM access enable
//   sram_write_o        SRAM write strobe
//   sram_tag_i          hit line tag, or LRU victim tag on a miss
//   sram_data_i         hit line, or LRU victim line on a miss
//   sram_hit_i          lookup hit
//   mem_addr_o          line address (bits [4:0] are zero)
//   mem_data_o          write-back data
//   mem_enable_o        memory request (registered)
//   mem_write_o         1 = write-back, 0 = fill (registered)
//   mem_data_i          fill data, valid with mem_ack_i
//   mem_ack_i           one-cycle completion pulse
// ---------------------------------------------------------------------------
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [3:0]   sram_addr_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    input  logic         sram_hit_i,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_READMISS,
        S_READMISSOK
    } state_e;

    state_e         state_q,      state_d;
    logic           mem_enable_q, mem_enable_d;
    logic           mem_write_q,  mem_write_d;
    logic [31:0]    mem_addr_q,   mem_addr_d;
    logic [255:0]   mem_data_q,   mem_data_d;

    logic           req;
    logic [22:0]    cpu_tag;
    logic [3:0]     cpu_index;
    logic [2:0]     cpu_word;
    logic [7:0]     word_bit;
    logic [31:0]    fill_addr;
    logic [31:0]    victim_addr;
    logic           victim_dirty;
    logic [255:0]   merged_line;
    logic [1:0]     unused_addr_bits;

    // Address decode
    assign req              = cpu_MemRead_i | cpu_MemWrite_i;
    assign cpu_tag          = cpu_addr_i[31:9];
    assign cpu_index        = cpu_addr_i[8:5];
    assign cpu_word         = cpu_addr_i[4:2];
    assign word_bit         = {cpu_word, 5'b0};
    assign unused_addr_bits = cpu_addr_i[1:0];

    assign fill_addr    = {cpu_tag, cpu_index, 5'b0};
    assign victim_addr  = {sram_tag_i[22:0], cpu_index, 5'b0};
    assign victim_dirty = sram_tag_i[24] & sram_tag_i[23];

    // Store-hit line: current line with the addressed word replaced
    always_comb begin
        merged_line                  = sram_data_i;
        merged_line[word_bit +: 32]  = cpu_data_i;
    end

    // -----------------------------------------------------------------------
    // Next-state and registered memory-interface values
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;

        case (state_q)
            S_IDLE: begin
                if (req && !sram_hit_i) begin
                    state_d = S_MISS;
                end
            end

            // The SRAM presents the LRU victim here because the lookup still misses
            S_MISS: begin
                mem_enable_d = 1'b1;
                if (victim_dirty) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = victim_addr;
                    mem_data_d  = sram_data_i;
                    state_d     = S_WRITEBACK;
                end else begin
                    mem_write_d = 1'b0;
                    mem_addr_d  = fill_addr;
                    state_d     = S_READMISS;
                end
            end

            // Enable stays high: the fill request follows directly on the ack
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = fill_addr;
                    state_d      = S_READMISS;
                end
            end

            S_READMISS: begin
                if (mem_ack_i) begin
                    mem_enable_d = 1'b0;
                    state_d      = S_READMISSOK;
                end
            end

            S_READMISSOK: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // -----------------------------------------------------------------------
    // Combinational CPU / SRAM outputs, all forced low during reset
    // -----------------------------------------------------------------------
    always_comb begin
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        sram_addr_o   = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;

        if (!rst_i) begin
            sram_addr_o   = cpu_index;
            sram_enable_o = req;
            sram_tag_o    = {1'b1, 1'b0, cpu_tag};
            cpu_data_o    = sram_data_i[word_bit +: 32];

            case (state_q)
                S_IDLE: begin
                    cpu_stall_o = req & ~sram_hit_i;
                    if (cpu_MemWrite_i && sram_hit_i) begin
                        sram_write_o = 1'b1;
                        sram_data_o  = merged_line;
                        sram_tag_o   = {1'b1, 1'b1, cpu_tag};
                    end
                end

                // Fill lands in the SRAM on the ack cycle as a clean line
                S_READMISS: begin
                    cpu_stall_o = 1'b1;
                    if (mem_ack_i) begin
                        sram_enable_o = 1'b1;
                        sram_write_o  = 1'b1;
                        sram_data_o   = mem_data_i;
                        sram_tag_o    = {1'b1, 1'b0, cpu_tag};
                    end
                end

                default: begin
                    cpu_stall_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic         cpu_MemRead_i = 1'b0;
    logic         cpu_MemWrite_i = 1'b0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- architectural reference: flat word memory ----------------
    logic [31:0]  ref_mem   [int unsigned];   // keyed by byte address >> 2
    logic [255:0] mem_lines [int unsigned];   // backing memory, keyed by address >> 5
    logic [31:0]  exp_q [$];                  // expected load results
    int           fixed_lat = 0;

    typedef struct {
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] data;
    } txn_t;
    txn_t txn_q [$];

    function automatic logic [31:0] init_word(input logic [31:0] waddr);
        return (waddr * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (ref_mem.exists(k)) return ref_mem[k];
        return init_word(k);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_get({a[31:5], 5'b0} + 32'(4*w));
        return l;
    endfunction

    function automatic logic [255:0] mem_get_line(input logic [31:0] a);
        logic [255:0] l;
        int unsigned  k;
        k = a >> 5;
        if (mem_lines.exists(k)) return mem_lines[k];
        for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word((k << 3) + w);
        return l;
    endfunction

    // ---------------- 2-way LRU SRAM environment model ----------------
    bit           v_a [16][2];
    bit           d_a [16][2];
    logic [22:0]  t_a [16][2];
    logic [255:0] l_a [16][2];
    bit           lru_a [16];
    logic         sel;

    always_comb begin
        logic hw;
        hw = 1'b0;
        sram_hit_i = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (v_a[sram_addr_o][w] && t_a[sram_addr_o][w] == cpu_addr_i[31:9]) begin
                sram_hit_i = 1'b1;
                hw = w[0];
            end
        end
        sel = sram_hit_i ? hw : lru_a[sram_addr_o];
        sram_tag_i  = {v_a[sram_addr_o][sel], d_a[sram_addr_o][sel], t_a[sram_addr_o][sel]};
        sram_data_i = l_a[sram_addr_o][sel];
    end

    always @(posedge clk_i) begin
        if (sram_enable_o === 1'b1) begin
            if (sram_write_o === 1'b1) begin
                v_a[sram_addr_o][sel] <= sram_tag_o[24];
                d_a[sram_addr_o][sel] <= sram_tag_o[23];
                t_a[sram_addr_o][sel] <= sram_tag_o[22:0];
                l_a[sram_addr_o][sel] <= sram_data_o;
            end
            if (sram_write_o === 1'b1 || sram_hit_i) lru_a[sram_addr_o] <= ~sel;
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        int           cnt;
        int           lat;
        logic [31:0]  s_addr;
        logic         s_wr;
        logic [255:0] s_data;
        cnt = 0;
        lat = 1;
        s_addr = '0;
        s_wr = 1'b0;
        s_data = '0;
        forever begin
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            for (int w = 0; w < 8; w++) mem_data_i[32*w +: 32] = $urandom;
            if (mem_enable_o !== 1'b1) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    lat    = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
                    s_addr = mem_addr_o;
                    s_wr   = mem_write_o;
                    s_data = mem_data_o;
                    chk("mem_addr_align", mem_addr_o[4:0], 0);
                end else begin
                    chk("mem_ctrl_stable", {s_wr, s_addr}, {mem_write_o, mem_addr_o});
                    if (s_wr) chk("mem_data_stable", mem_data_o, s_data);
                end
                cnt++;
                if (cnt == lat) begin
                    mem_ack_i = 1'b1;
                    if (s_wr) begin
                        mem_lines[s_addr >> 5] = s_data;
                    end else begin
                        s_data     = mem_get_line(s_addr);
                        mem_data_i = s_data;
                    end
                    txn_q.push_back('{addr: s_addr, wr: s_wr, data: s_data});
                    cnt = 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [255:0] exp_line;
        forever begin
            @(negedge clk_i);
            if (rst_i === 1'b0) begin
                if (cpu_MemRead_i && cpu_stall_o === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL load_unexpected actual=%0h required=none", cpu_data_o);
                    end else begin
                        chk("load_data", cpu_data_o, exp_q.pop_front());
                    end
                end
                if (sram_write_o === 1'b1) begin
                    if (cpu_MemWrite_i && cpu_stall_o === 1'b0) begin
                        exp_line = sram_data_i;
                        exp_line[{cpu_addr_i[4:2], 5'b0} +: 32] = cpu_data_i;
                        chk("store_tag", sram_tag_o, {2'b11, cpu_addr_i[31:9]});
                        chk("store_line", sram_data_o, exp_line);
                    end else if (cpu_stall_o === 1'b1 && mem_ack_i) begin
                        chk("fill_tag", sram_tag_o, {2'b10, cpu_addr_i[31:9]});
                        chk("fill_line", sram_data_o, mem_data_i);
                        chk("fill_enable", sram_enable_o, 1);
                    end else begin
                        chk("sram_write_spurious", sram_write_o, 0);
                    end
                end else if (cpu_MemWrite_i && cpu_stall_o === 1'b0) begin
                    chk("store_write_strobe", sram_write_o, 1);
                end
            end
        end
    end

    // ---------------- CPU driver ----------------
    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output int stalls, output int encyc);
        bit done;
        @(posedge clk_i); #1;
        cpu_addr_i     = a;
        cpu_data_i     = d;
        cpu_MemRead_i  = ~wr;
        cpu_MemWrite_i = wr;
        if (wr) ref_mem[a >> 2] = d;
        else    exp_q.push_back(ref_get(a));
        stalls = 0;
        encyc  = 0;
        done   = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk_i);
            if (mem_enable_o === 1'b1) encyc++;
            if (cpu_stall_o === 1'b0) done = 1'b1;
            else stalls++;
        end
        chk("access_completes", done, 1);
        if (encyc == 0) chk("hit_stall", stalls, 0);
        else            chk("miss_stall", stalls, 3 + encyc);
    endtask

    task automatic idle_bus();
        @(posedge clk_i); #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           st;
        int           en;
        logic [255:0] l;
        bit           seen;

        // Reset with a request present: everything quiet
        cpu_addr_i    = 32'h204;
        cpu_MemRead_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mem_enable", mem_enable_o, 0);
        chk("rst_mem_write", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        @(negedge clk_i);
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_sram_enable", sram_enable_o, 0);
        chk("rst_sram_write", sram_write_o, 0);
        chk("rst_cpu_data", cpu_data_o, 0);
        @(posedge clk_i); #1;
        rst_i         = 1'b0;
        cpu_MemRead_i = 1'b0;

        // Clean read miss with a 10-cycle memory
        ref_mem[32'h204 >> 2] = 32'hDEADBEEF;
        l = mem_get_line(32'h200);
        l[63:32] = 32'hDEADBEEF;
        mem_lines[32'h200 >> 5] = l;
        fixed_lat = 10;
        txn_q.delete();
        do_access(1'b0, 32'h204, 0, st, en);
        chk("clean_miss_stall13", st, 13);
        chk("clean_miss_txns", txn_q.size(), 1);
        if (txn_q.size() > 0) chk("clean_miss_addr", {txn_q[0].wr, txn_q[0].addr}, {1'b0, 32'h200});

        // Read hit, store hit, load back
        fixed_lat = 4;
        do_access(1'b0, 32'h204, 0, st, en);
        chk("read_hit_no_mem", en, 0);
        do_access(1'b1, 32'h208, 32'h12345678, st, en);
        chk("store_hit_no_stall", st, 0);
        do_access(1'b0, 32'h208, 0, st, en);
        chk("load_after_store_hit", st, 0);

        // Dirty eviction in set 0
        do_access(1'b0, 32'h400, 0, st, en);
        txn_q.delete();
        do_access(1'b0, 32'h600, 0, st, en);
        chk("dirty_stall_continuous", st, 3 + 4 + 4);
        chk("dirty_txns", txn_q.size(), 2);
        if (txn_q.size() == 2) begin
            chk("wb_addr", {txn_q[0].wr, txn_q[0].addr}, {1'b1, 32'h200});
            chk("wb_data", txn_q[0].data, ref_line(32'h200));
            chk("fill_after_wb", {txn_q[1].wr, txn_q[1].addr}, {1'b0, 32'h600});
        end
        do_access(1'b0, 32'h208, 0, st, en);

        // Reset in the middle of a write-back in set 1
        do_access(1'b1, 32'h024, 32'hCAFEF00D, st, en);
        do_access(1'b0, 32'h220, 0, st, en);
        fixed_lat = 8;
        txn_q.delete();
        @(posedge clk_i); #1;
        cpu_addr_i     = 32'h420;
        cpu_MemRead_i  = 1'b1;
        cpu_MemWrite_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk_i);
            if (mem_enable_o === 1'b1 && mem_write_o === 1'b1) seen = 1'b1;
        end
        chk("wb_started", seen, 1);
        chk("wb_addr_set1", mem_addr_o, 32'h020);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_stall", cpu_stall_o, 0);
        chk("midrst_sram_write", sram_write_o, 0);
        chk("midrst_sram_enable", sram_enable_o, 0);
        @(posedge clk_i); #1;
        rst_i         = 1'b0;
        cpu_MemRead_i = 1'b0;
        chk("midrst_mem_enable", mem_enable_o, 0);
        chk("midrst_mem_write", mem_write_o, 0);
        @(negedge clk_i);
        chk("midrst_idle_stall", cpu_stall_o, 0);
        chk("midrst_no_txn", txn_q.size(), 0);
        fixed_lat = 4;
        do_access(1'b0, 32'h420, 0, st, en);
        chk("reissue_stall", st, 3 + 4 + 4);
        if (txn_q.size() > 0) chk("reissue_wb", {txn_q[0].wr, txn_q[0].addr, txn_q[0].data[31:0]},
                                   {1'b1, 32'h020, ref_get(32'h020)});
        do_access(1'b0, 32'h024, 0, st, en);

        // Idle: no request for 20 cycles
        idle_bus();
        repeat (20) begin
            @(negedge clk_i);
            chk("idle_quiet", {sram_enable_o, mem_enable_o, cpu_stall_o}, 0);
        end

        // Randomised traffic over a small address window to force conflicts
        fixed_lat = 0;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
                ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            do_access($urandom_range(0, 1) == 1, a, $urandom, st, en);
        end
        idle_bus();
        repeat (3) @(negedge clk_i);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
